quadrature_filter: RTL

QUADRATURE_FILTER -- requirements
Module: quadrature_filter

---
 rtl/quadrature_filter_if.sv | 28 ++
 rtl/quadrature_filter.sv | 114 +++++++++++
 2 files changed

// File: rtl/quadrature_filter_if.sv
// Signal bundle between a quadrature glitch filter and its surroundings:
// raw encoder pins and configuration in, filtered levels and status out.
interface quadrature_filter_if #(
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter int unsigned FILTER_WIDTH  = 8
);
    logic                     raw_a;
    logic                     raw_b;
    logic [FILTER_WIDTH-1:0]  filter_len;
    logic                     clear_glitch_count;
    logic                     out_a;
    logic                     out_b;
    logic                     out_valid;
    logic                     edge_a;
    logic                     edge_b;
    logic                     dual_edge_err;
    logic [COUNTER_WIDTH-1:0] glitch_count;

    modport master (
        output raw_a, raw_b, filter_len, clear_glitch_count,
        input  out_a, out_b, out_valid, edge_a, edge_b, dual_edge_err, glitch_count
    );

    modport slave (
        input  raw_a, raw_b, filter_len, clear_glitch_count,
        output out_a, out_b, out_valid, edge_a, edge_b, dual_edge_err, glitch_count
    );
endinterface

// File: rtl/quadrature_filter.sv
// Quadrature input conditioner: synchronizes both encoder channels, accepts a
// level change only after filter_len stable cycles, and counts rejected pulses.
module quadrature_filter #(
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter int unsigned FILTER_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    quadrature_filter_if.slave   bus
);

    typedef enum logic [1:0] {PRIME0, PRIME1, RUN} state_t;

    state_t                   state;
    logic                     sync1_a, sync2_a, sync1_b, sync2_b;
    logic [FILTER_WIDTH-1:0]  cnt_a, cnt_b;
    logic                     out_a_q, out_b_q, out_valid_q;
    logic                     edge_a_q, edge_b_q, dual_q;
    logic [COUNTER_WIDTH-1:0] glitch_q;

    logic [FILTER_WIDTH-1:0]  len_m1;
    logic                     qual_a, qual_b, glitch_a, glitch_b;
    logic [COUNTER_WIDTH-1:0] inc_w, glitch_nxt;

    always_comb begin
        len_m1     = (bus.filter_len == '0) ? '0 : bus.filter_len - FILTER_WIDTH'(1);
        qual_a     = (sync2_a != out_a_q) && (cnt_a >= len_m1);
        qual_b     = (sync2_b != out_b_q) && (cnt_b >= len_m1);
        glitch_a   = (state == RUN) && (sync2_a == out_a_q) && (cnt_a != '0);
        glitch_b   = (state == RUN) && (sync2_b == out_b_q) && (cnt_b != '0);
        inc_w      = COUNTER_WIDTH'({1'b0, glitch_a} + {1'b0, glitch_b});
        // ~glitch_q is the remaining headroom before all-ones
        glitch_nxt = (inc_w > ~glitch_q) ? '1 : glitch_q + inc_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PRIME0;
            sync1_a     <= 1'b0;
            sync2_a     <= 1'b0;
            sync1_b     <= 1'b0;
            sync2_b     <= 1'b0;
            cnt_a       <= '0;
            cnt_b       <= '0;
            out_a_q     <= 1'b0;
            out_b_q     <= 1'b0;
            out_valid_q <= 1'b0;
            edge_a_q    <= 1'b0;
            edge_b_q    <= 1'b0;
            dual_q      <= 1'b0;
            glitch_q    <= '0;
        end else begin
            sync1_a  <= bus.raw_a;
            sync2_a  <= sync1_a;
            sync1_b  <= bus.raw_b;
            sync2_b  <= sync1_b;
            edge_a_q <= 1'b0;
            edge_b_q <= 1'b0;
            dual_q   <= 1'b0;

            if (bus.clear_glitch_count)
                glitch_q <= '0;
            else
                glitch_q <= glitch_nxt;

            unique case (state)
                PRIME0: state <= PRIME1;
                PRIME1: begin
                    // Load the value sync2 takes on this edge so out_x already
                    // equals s_x when RUN begins, avoiding a spurious edge.
                    state       <= RUN;
                    out_a_q     <= sync1_a;
                    out_b_q     <= sync1_b;
                    out_valid_q <= 1'b1;
                    cnt_a       <= '0;
                    cnt_b       <= '0;
                end
                RUN: begin
                    if (sync2_a == out_a_q) begin
                        cnt_a <= '0;
                    end else if (qual_a) begin
                        out_a_q  <= sync2_a;
                        cnt_a    <= '0;
                        edge_a_q <= 1'b1;
                    end else begin
                        cnt_a <= cnt_a + FILTER_WIDTH'(1);
                    end

                    if (sync2_b == out_b_q) begin
                        cnt_b <= '0;
                    end else if (qual_b) begin
                        out_b_q  <= sync2_b;
                        cnt_b    <= '0;
                        edge_b_q <= 1'b1;
                    end else begin
                        cnt_b <= cnt_b + FILTER_WIDTH'(1);
                    end

                    dual_q <= qual_a && qual_b;
                end
                default: state <= PRIME0;
            endcase
        end
    end

    assign bus.out_a         = out_a_q;
    assign bus.out_b         = out_b_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.edge_a        = edge_a_q;
    assign bus.edge_b        = edge_b_q;
    assign bus.dual_edge_err = dual_q;
    assign bus.glitch_count  = glitch_q;

endmodule
